nvm_sipo_rx: RTL and testbench

Serial-in/parallel-out receiver for the NVM reader serial datapath. Sits directly downstream of the PISO serializer and consumes its one-bit `D_Out` stream. It reassembles `WIDTH`-bit words, groups them into frames of `FRAME_BYTES` words, and presents each word on a valid/ready output register. It flags any word lost because the consumer stalled.

---
 rtl/nvm_rx_pkg.sv | 12 +
 rtl/nvm_rx_hold.sv | 45 ++++
 rtl/nvm_sipo_rx.sv | 128 ++++++++++++
 tb/tb_nvm_sipo_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nvm_rx_pkg.sv
// Shared types and default sizes for the NVM reader serial receive path.
package nvm_rx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam int NVM_WORD_W      = 8;
    localparam int NVM_FRAME_BYTES = 4;

endpackage

// File: rtl/nvm_rx_hold.sv
// One-entry valid/ready hold register with a sticky overrun flag.
// A word offered while the entry is occupied and not being drained is dropped.
module nvm_rx_hold
    import nvm_rx_pkg::*;
#(
    parameter int WIDTH = NVM_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             clear_ovr,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overrun
);

    logic free;

    // A consume and a load on the same edge leave the entry occupied with the new word.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && free) begin
                q     <= data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (clear_ovr) begin
                overrun <= 1'b0;
            end else if (load && !free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvm_sipo_rx.sv
// Serial-in/parallel-out receiver: rebuilds words from the PISO bit stream,
// counts them into frames and hands each word to a valid/ready hold register.
module nvm_sipo_rx
    import nvm_rx_pkg::*;
#(
    parameter int WIDTH       = NVM_WORD_W,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int FRAME_BYTES = NVM_FRAME_BYTES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Shift_En,
    input  logic             D_In,
    input  logic             Ready,
    output logic [WIDTH-1:0] D_Out,
    output logic             Valid,
    output logic             Frame_Done,
    output logic             Overrun,
    output logic             Busy
);

    localparam int BIT_W  = $clog2(WIDTH);
    localparam int WORD_W = $clog2(FRAME_BYTES + 1);

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_BYTES - 1);

    rx_state_t         state;
    rx_state_t         next_state;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  next_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_cnt;
    logic              restart;
    logic              shift;
    logic              word_done;
    logic              frame_end;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start wins over Shift_En, so the bit on a restart edge never enters the word.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        shift      = 1'b0;
        word_done  = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    next_state = RECV;
                    restart    = 1'b1;
                end
            end
            RECV: begin
                if (Start) begin
                    restart = 1'b1;
                end else if (Shift_En) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        word_done = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            frame_end  = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        next_sr = sr;
        if (MSB_FIRST) begin
            next_sr = {sr[WIDTH-2:0], D_In};
        end else begin
            next_sr = {D_In, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sr         <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= frame_end;
            if (restart) begin
                sr       <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else if (shift) begin
                sr <= next_sr;
                if (word_done) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + WORD_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    assign Busy = (state == RECV);

    nvm_rx_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (word_done),
        .data     (next_sr),
        .clear_ovr(restart),
        .ready    (Ready),
        .q        (D_Out),
        .valid    (Valid),
        .overrun  (Overrun)
    );

endmodule

// File: tb/tb_nvm_sipo_rx.sv
// Directed bench for nvm_sipo_rx: MSB-first frames, an LSB-first single-word
// frame with gapped shifting, and a three-word loopback from a PISO model.
module tb_nvm_sipo_rx;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Main instance: MSB-first, two words per frame
    logic       start, shift_en, d_in, ready;
    logic [7:0] d_out;
    logic       valid, frame_done, overrun, busy;

    // LSB-first instance, one word per frame
    logic       start_l, shift_en_l, d_in_l, ready_l;
    logic [7:0] d_out_l;
    logic       valid_l, frame_done_l, overrun_l, busy_l;

    // Loopback instance fed from a PISO model, three words per frame
    logic       start_p, shift_en_p, d_in_p, ready_p;
    logic [7:0] d_out_p;
    logic       valid_p, frame_done_p, overrun_p, busy_p;
    logic [7:0] piso_reg;

    assign d_in_p = piso_reg[7];

    int assert_count = 0;
    int fail_count   = 0;

    nvm_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .FRAME_BYTES(2)) dut (
        .CLK(clk), .RST(rst_n), .Start(start), .Shift_En(shift_en), .D_In(d_in),
        .Ready(ready), .D_Out(d_out), .Valid(valid), .Frame_Done(frame_done),
        .Overrun(overrun), .Busy(busy)
    );

    nvm_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0), .FRAME_BYTES(1)) dut_lsb (
        .CLK(clk), .RST(rst_n), .Start(start_l), .Shift_En(shift_en_l), .D_In(d_in_l),
        .Ready(ready_l), .D_Out(d_out_l), .Valid(valid_l), .Frame_Done(frame_done_l),
        .Overrun(overrun_l), .Busy(busy_l)
    );

    nvm_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .FRAME_BYTES(3)) dut_lb (
        .CLK(clk), .RST(rst_n), .Start(start_p), .Shift_En(shift_en_p), .D_In(d_in_p),
        .Ready(ready_p), .D_Out(d_out_p), .Valid(valid_p), .Frame_Done(frame_done_p),
        .Overrun(overrun_p), .Busy(busy_p)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge they depend on
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_en = 1'b1;
        d_in     = b;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] lsb_bits;
        int         gaps [8];
        logic [7:0] lb_words [3];

        rst_n = 1'b0;
        start = 0; shift_en = 0; d_in = 0; ready = 0;
        start_l = 0; shift_en_l = 0; d_in_l = 0; ready_l = 0;
        start_p = 0; shift_en_p = 0; ready_p = 0; piso_reg = '0;
        tick();
        tick();

        checkOutput("reset_dout", 32'(d_out), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Basic two-word frame, consumer always ready
        ready = 1'b1;
        pulse_start();
        checkOutput("basic_busy_rise", 32'(busy), 32'h1);
        applyStimulus(8'hA5);
        checkOutput("basic_w0_dout", 32'(d_out), 32'hA5);
        checkOutput("basic_w0_valid", 32'(valid), 32'h1);
        checkOutput("basic_w0_fdone", 32'(frame_done), 32'h0);
        applyStimulus(8'h3C);
        checkOutput("basic_w1_dout", 32'(d_out), 32'h3C);
        checkOutput("basic_w1_valid", 32'(valid), 32'h1);
        checkOutput("basic_w1_fdone", 32'(frame_done), 32'h1);
        checkOutput("basic_busy_fall", 32'(busy), 32'h0);
        checkOutput("basic_overrun", 32'(overrun), 32'h0);
        tick();
        checkOutput("basic_fdone_pulse", 32'(frame_done), 32'h0);
        checkOutput("basic_consumed", 32'(valid), 32'h0);

        // Stalled consumer drops the second word
        ready = 1'b0;
        pulse_start();
        applyStimulus(8'h11);
        checkOutput("ovr_w0_dout", 32'(d_out), 32'h11);
        applyStimulus(8'h22);
        checkOutput("ovr_dout_kept", 32'(d_out), 32'h11);
        checkOutput("ovr_valid", 32'(valid), 32'h1);
        checkOutput("ovr_flag", 32'(overrun), 32'h1);
        checkOutput("ovr_fdone", 32'(frame_done), 32'h1);
        ready = 1'b1;
        tick();
        checkOutput("ovr_drain_valid", 32'(valid), 32'h0);
        checkOutput("ovr_sticky", 32'(overrun), 32'h1);

        // Consume and load on the same edge
        ready = 1'b0;
        pulse_start();
        checkOutput("sim_start_clears_ovr", 32'(overrun), 32'h0);
        applyStimulus(8'h11);
        for (int i = 7; i >= 1; i--) begin
            send_bit(1'(8'h22 >> i));
        end
        checkOutput("sim_hold_stable", 32'(d_out), 32'h11);
        ready = 1'b1;
        send_bit(1'b0);
        checkOutput("sim_valid", 32'(valid), 32'h1);
        checkOutput("sim_dout", 32'(d_out), 32'h22);
        checkOutput("sim_overrun", 32'(overrun), 32'h0);
        checkOutput("sim_fdone", 32'(frame_done), 32'h1);

        // Reset mid-word
        ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        rst_n = 1'b0;
        tick();
        checkOutput("rst_mid_dout", 32'(d_out), 32'h00);
        checkOutput("rst_mid_valid", 32'(valid), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        pulse_start();
        applyStimulus(8'h6C);
        checkOutput("rst_after_dout", 32'(d_out), 32'h6C);
        checkOutput("rst_after_valid", 32'(valid), 32'h1);

        // Restart after 3 bits; the shifted bit on the Start edge is discarded
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
        end
        start    = 1'b1;
        shift_en = 1'b1;
        d_in     = 1'b1;
        tick();
        start    = 1'b0;
        shift_en = 1'b0;
        applyStimulus(8'h5A);
        checkOutput("restart_dout", 32'(d_out), 32'h5A);
        checkOutput("restart_valid", 32'(valid), 32'h1);
        checkOutput("restart_fdone", 32'(frame_done), 32'h0);
        checkOutput("restart_busy", 32'(busy), 32'h1);

        // LSB-first word with gaps between bits
        lsb_bits = 8'b1010_0101;
        gaps     = '{0, 2, 1, 3, 0, 1, 2, 0};
        ready_l  = 1'b1;
        start_l  = 1'b1;
        tick();
        start_l  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checkOutput("lsb_pre_valid", 32'(valid_l), 32'h0);
            end
            shift_en_l = 1'b1;
            d_in_l     = lsb_bits[7 - i];
            tick();
            shift_en_l = 1'b0;
            repeat (gaps[i]) tick();
        end
        checkOutput("lsb_dout", 32'(d_out_l), 32'hA5);
        checkOutput("lsb_busy_idle", 32'(busy_l), 32'h0);
        ready_l    = 1'b0;
        shift_en_l = 1'b1;
        d_in_l     = 1'b0;
        repeat (3) tick();
        shift_en_l = 1'b0;
        checkOutput("lsb_idle_ignores_shift", 32'(d_out_l), 32'hA5);
        checkOutput("lsb_idle_busy", 32'(busy_l), 32'h0);

        // Loopback from PISO model, back-to-back words
        lb_words = '{8'h02, 8'h04, 8'h06};
        ready_p  = 1'b1;
        start_p  = 1'b1;
        tick();
        start_p  = 1'b0;
        for (int w = 0; w < 3; w++) begin
            piso_reg = lb_words[w];
            for (int b = 0; b < 8; b++) begin
                shift_en_p = 1'b1;
                tick();
                piso_reg = piso_reg << 1;
            end
            shift_en_p = 1'b0;
            checkOutput($sformatf("lb_word%0d", w), 32'(d_out_p), 32'(lb_words[w]));
            checkOutput($sformatf("lb_valid%0d", w), 32'(valid_p), 32'h1);
        end
        checkOutput("lb_overrun", 32'(overrun_p), 32'h0);
        checkOutput("lb_fdone", 32'(frame_done_p), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
